add_round_key_stage: RTL and testbench

- Registered AddRoundKey stage directly downstream of the MixColumns stage. It XORs each 128-bit state with the round key selected by an internal round counter.
- Holds the full expanded key schedule (NR+1 round keys), which a key loader writes through a dedicated write port.
- Uses a valid/ready handshake on both sides. Sustains one state per cycle and tags each output with its round index and a last-round flag.

---
 rtl/aes_pkg.sv | 12 +
 rtl/round_key_store.sv | 48 ++++
 rtl/add_round_key_stage.sv | 114 +++++++++++
 tb/tb_add_round_key_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES datapath types and round-count constants
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [127:0] rkey_t;

  localparam int AES128_NR     = 10;
  localparam int AES192_NR     = 12;
  localparam int AES256_NR     = 14;
  localparam int RND_W_DEFAULT = 4;

endpackage

// File: rtl/round_key_store.sv
// rtl/round_key_store.sv - NR+1 entry round-key register file, sync write / async read
// Optional ARK_ZEROIZE_EN adds a zeroize input that clears every key.
module round_key_store
  import aes_pkg::*;
#(
  parameter int NR    = AES128_NR,
  parameter int RND_W = RND_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef ARK_ZEROIZE_EN
  input  logic             zeroize,
`endif
  input  logic             wr_en,
  input  logic [RND_W-1:0] wr_idx,
  input  logic [127:0]     wr_data,
  input  logic [RND_W-1:0] rd_idx,
  output logic [127:0]     rd_key
);

  localparam logic [RND_W-1:0] MAX_IDX = RND_W'(NR);

  rkey_t key_q [NR+1];
  logic  wr_ok;

  // Indices above NR have no backing register and are dropped silently.
  assign wr_ok = wr_en && (wr_idx <= MAX_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NR; i++) key_q[i] <= '0;
    end
`ifdef ARK_ZEROIZE_EN
    else if (zeroize) begin
      for (int i = 0; i <= NR; i++) key_q[i] <= '0;
    end
`endif
    else if (wr_ok) begin
      key_q[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    rd_key = '0;
    if (rd_idx <= MAX_IDX) rd_key = key_q[rd_idx];
  end

endmodule

// File: rtl/add_round_key_stage.sv
// rtl/add_round_key_stage.sv - registered AddRoundKey stage with round counter and handshake
// Optional ARK_ZEROIZE_EN adds a zeroize input clearing keys, counter and output register.
module add_round_key_stage
  import aes_pkg::*;
#(
  parameter int NR    = AES128_NR,
  parameter int RND_W = RND_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef ARK_ZEROIZE_EN
  input  logic             zeroize,
`endif
  input  logic             key_wr_en,
  input  logic [RND_W-1:0] key_wr_idx,
  input  logic [127:0]     key_wr_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic [127:0]     in_state,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_state,
  output logic [RND_W-1:0] out_round,
  output logic             out_last
);

  localparam logic [RND_W-1:0] MAX_IDX = RND_W'(NR);

  logic             out_valid_q, out_valid_d;
  state_t           out_state_q, out_state_d;
  logic [RND_W-1:0] out_round_q, out_round_d;
  logic             out_last_q,  out_last_d;
  logic [RND_W-1:0] rnd_q,       rnd_d;

  logic [RND_W-1:0] sel;
  logic             sel_last;
  logic             acc;
  rkey_t            sel_key;

  round_key_store #(
    .NR    (NR),
    .RND_W (RND_W)
  ) u_store (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef ARK_ZEROIZE_EN
    .zeroize (zeroize),
`endif
    .wr_en   (key_wr_en),
    .wr_idx  (key_wr_idx),
    .wr_data (key_wr_data),
    .rd_idx  (sel),
    .rd_key  (sel_key)
  );

`ifdef ARK_ZEROIZE_EN
  assign in_ready = (!out_valid_q || out_ready) && !zeroize;
`else
  assign in_ready = !out_valid_q || out_ready;
`endif

  assign acc      = in_valid && in_ready;
  assign sel      = in_first ? '0 : rnd_q;
  assign sel_last = (sel == MAX_IDX);

  always_comb begin
    out_valid_d = out_valid_q;
    out_state_d = out_state_q;
    out_round_d = out_round_q;
    out_last_d  = out_last_q;
    rnd_d       = rnd_q;
    if (acc) begin
      out_valid_d = 1'b1;
      out_state_d = in_state ^ sel_key;
      out_round_d = sel;
      out_last_d  = sel_last;
      rnd_d       = sel_last ? '0 : sel + RND_W'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
`ifdef ARK_ZEROIZE_EN
    if (zeroize) begin
      out_valid_d = 1'b0;
      out_state_d = '0;
      out_round_d = '0;
      out_last_d  = 1'b0;
      rnd_d       = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_state_q <= '0;
      out_round_q <= '0;
      out_last_q  <= 1'b0;
      rnd_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_state_q <= out_state_d;
      out_round_q <= out_round_d;
      out_last_q  <= out_last_d;
      rnd_q       <= rnd_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_state = out_state_q;
  assign out_round = out_round_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_add_round_key_stage.sv
// tb/tb_add_round_key_stage.sv - self-checking bench for add_round_key_stage
// Exercises the ARK_ZEROIZE_EN feature when that macro is defined.
module tb_add_round_key_stage;

  localparam int NR    = 10;
  localparam int RND_W = 4;
`ifdef ARK_ZEROIZE_EN
  localparam bit ZE = 1'b1;
`else
  localparam bit ZE = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             zeroize = 1'b0;
  logic             key_wr_en = 1'b0;
  logic [RND_W-1:0] key_wr_idx = '0;
  logic [127:0]     key_wr_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_first = 1'b0;
  logic [127:0]     in_state = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [127:0]     out_state;
  logic [RND_W-1:0] out_round;
  logic             out_last;

  always #5 clk = ~clk;

  add_round_key_stage #(.NR(NR), .RND_W(RND_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef ARK_ZEROIZE_EN
    .zeroize     (zeroize),
`endif
    .key_wr_en   (key_wr_en),
    .key_wr_idx  (key_wr_idx),
    .key_wr_data (key_wr_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_first    (in_first),
    .in_state    (in_state),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_state   (out_state),
    .out_round   (out_round),
    .out_last    (out_last)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Transaction-level reference: key table, next round number, last emitted beat.
  logic [127:0] m_key [0:NR];
  int           m_rnd;
  bit           m_valid;
  logic [127:0] m_state;
  int           m_round;
  bit           m_last;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i <= NR; i++) m_key[i] = '0;
    m_rnd = 0; m_valid = 0; m_state = '0; m_round = 0; m_last = 0;
  endtask

  task automatic check_outputs();
    chk("out_valid", 128'(out_valid), 128'(m_valid));
    chk("out_state", out_state, m_state);
    chk("out_round", 128'(out_round), 128'(m_round));
    chk("out_last",  128'(out_last),  128'(m_last));
  endtask

  task automatic cycle(input bit v, input bit f, input logic [127:0] s, input bit r,
                       input bit we, input logic [3:0] wi, input logic [127:0] wd, input bit z);
    bit ready_e;
    int sel;
    in_valid = v; in_first = f; in_state = s; out_ready = r;
    key_wr_en = we; key_wr_idx = wi; key_wr_data = wd; zeroize = z;
    #1;
    ready_e = (!m_valid || r) && !zeroize;
    chk("in_ready", 128'(in_ready), 128'(ready_e));
    if (ZE && z) begin
      m_clear();
    end else begin
      if (v && ready_e) begin
        sel     = f ? 0 : m_rnd;
        m_state = s ^ m_key[sel];
        m_round = sel;
        m_last  = (sel == NR);
        m_valid = 1;
        m_rnd   = (sel == NR) ? 0 : sel + 1;
      end else if (r) begin
        m_valid = 0;
      end
      if (we && int'(wi) <= NR) m_key[wi] = wd;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    cycle(0, 0, '0, 1, 0, 4'd0, '0, 0);
  endtask

  initial begin
    logic [127:0] s, nk, pat;
    logic [3:0]   ib;
    m_clear();

    // Reset state
    @(negedge clk);
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_state", out_state, 128'(0));
    chk("rst_round", 128'(out_round), 128'(0));
    chk("rst_last",  128'(out_last), 128'(0));
    chk("rst_ready", 128'(in_ready), 128'(1));
    rst_n = 1'b1;

    // FIPS-197 initial AddRoundKey
    cycle(0, 0, '0, 1, 1, 4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 0);
    cycle(1, 1, 128'h3243f6a8885a308d313198a2e0370734, 1, 0, 4'd0, '0, 0);
    chk("fips_state", out_state, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    chk("fips_round", 128'(out_round), 128'(0));
    chk("fips_last",  128'(out_last), 128'(0));

    // Full 11-beat block with patterned keys
    for (int i = 0; i <= NR; i++) begin
      ib = i[3:0];
      cycle(0, 0, '0, 1, 1, ib, {32{ib}}, 0);
    end
    for (int i = 0; i <= NR; i++) begin
      ib = i[3:0];
      pat = {32{ib}};
      cycle(1, i == 0, '0, 1, 0, 4'd0, '0, 0);
      chk("blk_round", 128'(out_round), 128'(i));
      chk("blk_last",  128'(out_last), 128'(i == NR));
      chk("blk_state", out_state, pat);
    end
    cycle(1, 0, '0, 1, 0, 4'd0, '0, 0);
    chk("wrap_round", 128'(out_round), 128'(0));

    // Backpressure: stall three cycles, then drain in order
    for (int j = 0; j < 3; j++) begin
      cycle(1, 0, rand128(), 0, 0, 4'd0, '0, 0);
      chk("stall_round", 128'(out_round), 128'(0));
      chk("stall_valid", 128'(out_valid), 128'(1));
    end
    for (int j = 1; j <= 3; j++) begin
      cycle(1, 0, rand128(), 1, 0, 4'd0, '0, 0);
      chk("drain_round", 128'(out_round), 128'(j));
    end

    // Same-cycle write to key 0 with in_first uses the old key
    s  = rand128();
    nk = rand128();
    cycle(1, 1, s, 1, 1, 4'd0, nk, 0);
    chk("rbw_old", out_state, s);
    s = rand128();
    cycle(1, 1, s, 1, 0, 4'd0, '0, 0);
    chk("rbw_new", out_state, s ^ nk);
    cycle(0, 0, '0, 1, 1, 4'd15, rand128(), 0);
    for (int i = 0; i <= NR; i++) cycle(1, i == 0, rand128(), 1, 0, 4'd0, '0, 0);

    // Asynchronous reset mid-stream at round 5
    for (int i = 0; i <= 5; i++) cycle(1, i == 0, rand128(), 1, 0, 4'd0, '0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 128'(out_valid), 128'(0));
    chk("arst_state", out_state, 128'(0));
    m_clear();
    @(negedge clk);
    rst_n = 1'b1;
    s = rand128();
    cycle(1, 1, s, 1, 0, 4'd0, '0, 0);
    chk("arst_nokey", out_state, s);

`ifdef ARK_ZEROIZE_EN
    for (int i = 0; i <= NR; i++) cycle(0, 0, '0, 1, 1, i[3:0], rand128(), 0);
    for (int i = 0; i < 3; i++) cycle(1, i == 0, rand128(), 1, 0, 4'd0, '0, 0);
    cycle(1, 0, rand128(), 1, 1, 4'd4, rand128(), 1);
    chk("zer_valid", 128'(out_valid), 128'(0));
    s = rand128();
    cycle(1, 0, s, 1, 0, 4'd0, '0, 0);
    chk("zer_round", 128'(out_round), 128'(0));
    chk("zer_state", out_state, s);
`endif

    // Randomized traffic against the reference
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, rand128(),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            4'($urandom_range(0, 15)), rand128(), ZE && ($urandom_range(0, 31) == 0));
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
